// File: rtl/shuffle_pkg.sv
// Shared constants, FSM state type and the draw-mask helper for the card shuffler.
package shuffle_pkg;

  localparam int unsigned DECK_SIZE = 52;
  localparam int unsigned CARD_W    = 6;
  localparam logic [CARD_W-1:0] LFSR_TAPS = 6'b110000;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    SHUF,
    OUT,
    DONE
  } state_t;

  // Smallest 2^n-1 that covers i, so a masked draw is in range at least half the time.
  function automatic logic [CARD_W-1:0] mask(input logic [CARD_W-1:0] i);
    logic [CARD_W-1:0] m;
    m = '0;
    for (int unsigned b = 0; b < CARD_W; b++) begin
      if (i > m) m = {m[CARD_W-2:0], 1'b1};
    end
    return m;
  endfunction

endpackage

// File: rtl/shuffle_lfsr.sv
// 6-bit Fibonacci LFSR with seed load, step enable and a guard that never lets it hold zero.
module shuffle_lfsr
  import shuffle_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [CARD_W-1:0] seed,
  output logic [CARD_W-1:0] value
);

  logic [CARD_W-1:0] seed_safe;
  logic              feedback;

  always_comb begin
    seed_safe = (seed == '0) ? CARD_W'(1) : seed;
    feedback  = ^(value & LFSR_TAPS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= CARD_W'(1);
    end else if (load) begin
      value <= seed_safe;
    end else if (step) begin
      value <= {value[CARD_W-2:0], feedback};
    end
  end

endmodule

// File: rtl/shuffle.sv
// Fisher-Yates card shuffler: builds a deck, permutes it with LFSR draws, streams one card per cycle.
// Build option SHUFFLE_FREE_RUN_LFSR_EN: LFSR seeds once after reset and then free-runs in every state.
module shuffle
  import shuffle_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              shuffleFlag,
  input  logic [CARD_W-1:0] SEED,
  output logic              loadFlag,
  output logic [CARD_W-1:0] card
);

  localparam logic [CARD_W-1:0] LAST = CARD_W'(DECK_SIZE - 1);

  state_t            state;
  logic [CARD_W-1:0] i_idx;
  logic [CARD_W-1:0] o_idx;
  logic [CARD_W-1:0] deck [DECK_SIZE];
  logic [CARD_W-1:0] lfsr;
  logic [CARD_W-1:0] j;
  logic              accept;
  logic              lfsr_load;
  logic              lfsr_step;

`ifdef SHUFFLE_FREE_RUN_LFSR_EN
  logic seeded;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) seeded <= 1'b0;
    else      seeded <= 1'b1;
  end
`endif

  // Draw candidate and LFSR control.
  always_comb begin
    j      = lfsr & mask(i_idx);
    accept = (state == SHUF) && (j <= i_idx);
`ifdef SHUFFLE_FREE_RUN_LFSR_EN
    lfsr_load = !seeded;
    lfsr_step = seeded;
`else
    lfsr_load = (state == IDLE);
    lfsr_step = (state == SHUF);
`endif
  end

  shuffle_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .seed  (SEED),
    .value (lfsr)
  );

  // Deck storage is don't-care after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      for (int unsigned k = 0; k < DECK_SIZE; k++) deck[k] <= CARD_W'(k);
    end else if (accept) begin
      deck[i_idx] <= deck[j];
      deck[j]     <= deck[i_idx];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      loadFlag <= 1'b0;
      card     <= '0;
      i_idx    <= '0;
      o_idx    <= '0;
    end else begin
      loadFlag <= 1'b0;
      card     <= '0;
      case (state)
        IDLE: begin
          if (shuffleFlag) state <= INIT;
        end
        INIT: begin
          i_idx <= LAST;
          state <= SHUF;
        end
        SHUF: begin
          // Rejected draws simply wait for the next LFSR value.
          if (accept) begin
            if (i_idx == CARD_W'(1)) begin
              o_idx <= '0;
              state <= OUT;
            end else begin
              i_idx <= i_idx - CARD_W'(1);
            end
          end
        end
        OUT: begin
          loadFlag <= 1'b1;
          card     <= deck[o_idx];
          o_idx    <= o_idx + CARD_W'(1);
          if (o_idx == LAST) state <= DONE;
        end
        DONE: begin
          if (!shuffleFlag) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shuffle.sv
// Self-checking bench for shuffle: a behavioural Fisher-Yates model predicts every output cycle.
module tb_shuffle;

  localparam int NC  = 52;
  localparam int BIG = 32'h3fff_ffff;

  typedef logic [5:0] seq_t [NC];

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       shuffleFlag = 1'b0;
  logic [5:0] SEED = 6'b101011;
  logic       loadFlag;
  logic [5:0] card;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   exp_first = BIG;
  seq_t exp_cards;
  seq_t got;
  seq_t seq_a, seq_b, seq_c, seq_0, seq_1, seq_d;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shuffle dut (
    .clk         (clk),
    .rst         (rst),
    .shuffleFlag (shuffleFlag),
    .SEED        (SEED),
    .loadFlag    (loadFlag),
    .card        (card)
  );

  function automatic logic [5:0] lfsr_next(input logic [5:0] x);
    return {x[4:0], x[5] ^ x[4]};
  endfunction

  function automatic int mask_of(input int i);
    int m = 1;
    while (m < i) m = m * 2 + 1;
    return m;
  endfunction

  function automatic logic [5:0] eff(input logic [5:0] s);
    return (s == 6'd0) ? 6'd1 : s;
  endfunction

  function automatic int diffs(input seq_t a, input seq_t b);
    int n = 0;
    for (int k = 0; k < NC; k++) if (a[k] != b[k]) n++;
    return n;
  endfunction

`ifdef SHUFFLE_FREE_RUN_LFSR_EN
  // LFSR value the design should hold: seeded once after reset, then stepping every cycle.
  logic [5:0] ref_lfsr;
  logic       ref_seeded;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_lfsr   <= 6'd1;
      ref_seeded <= 1'b0;
    end else if (!ref_seeded) begin
      ref_lfsr   <= eff(SEED);
      ref_seeded <= 1'b1;
    end else begin
      ref_lfsr <= lfsr_next(ref_lfsr);
    end
  end
`endif

  task automatic chk(input bit ok, input string name, input int act, input int req);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Fisher-Yates over a card list, one LFSR draw per cycle; returns the cycle count.
  task automatic model(input logic [5:0] start, output int ncyc);
    int d[NC];
    int i, j, t;
    logic [5:0] l;
    for (int k = 0; k < NC; k++) d[k] = k;
    i = NC - 1;
    l = start;
    ncyc = 0;
    while (ncyc < 4000) begin
      ncyc++;
      j = int'(l) & mask_of(i);
      l = lfsr_next(l);
      if (j <= i) begin
        t = d[i]; d[i] = d[j]; d[j] = t;
        if (i == 1) break;
        i--;
      end
    end
    for (int k = 0; k < NC; k++) exp_cards[k] = 6'(d[k]);
  endtask

  task automatic check_cycle();
    int k;
    if (!rst) begin
      chk(loadFlag === 1'b0 && card === 6'd0, "reset_outputs", int'({loadFlag, card}), 0);
    end else if (cyc >= exp_first && cyc < exp_first + NC) begin
      k = cyc - exp_first;
      chk(loadFlag === 1'b1, $sformatf("strobe[%0d]", k), int'(loadFlag), 1);
      chk(card === exp_cards[k], $sformatf("card[%0d]", k), int'(card), int'(exp_cards[k]));
      got[k] = card;
    end else begin
      chk(loadFlag === 1'b0, "quiet_loadFlag", int'(loadFlag), 0);
      chk(card === 6'd0, "quiet_card", int'(card), 0);
    end
  endtask

  task automatic check_perm(input string nm);
    logic [63:0] seen = '0;
    int bad = 0;
    for (int k = 0; k < NC; k++) begin
      if (got[k] > 6'd51 || seen[got[k]]) bad++;
      seen[got[k]] = 1'b1;
    end
    chk(bad == 0, nm, bad, 0);
  endtask

  // Raise the request after an idle wait and arm the expected stream; returns once the design is idle-ready.
  task automatic arm_shuffle(input logic [5:0] seed, input int idle_wait);
    int e0, n;
    logic [5:0] start;
    @(negedge clk);
    SEED = seed;
    shuffleFlag = 1'b0;
    repeat (idle_wait) @(negedge clk);
    shuffleFlag = 1'b1;
    e0 = cyc + 1;
    @(posedge clk);
    @(posedge clk);
    #1;
`ifdef SHUFFLE_FREE_RUN_LFSR_EN
    start = ref_lfsr;
`else
    start = eff(seed);
`endif
    model(start, n);
    chk(n < 4000, "model_terminates", n, 4000);
    exp_first = e0 + n + 2;
  endtask

  task automatic run_shuffle(input logic [5:0] seed, input int idle_wait, input string nm);
    int guard = 0;
    arm_shuffle(seed, idle_wait);
    while (cyc < exp_first + NC && guard < 5000) begin
      @(posedge clk);
      guard++;
    end
    chk(guard < 5000, "stream_timeout", guard, 5000);
    repeat (5) @(negedge clk);
    shuffleFlag = 1'b0;
    exp_first = BIG;
    check_perm(nm);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    shuffleFlag = 1'b0;
    exp_first = BIG;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic mid_stream_reset();
    int guard = 0;
    arm_shuffle(6'b101011, 3);
    do begin
      @(posedge clk);
      #1;
      guard++;
    end while (cyc < exp_first + 10 && guard < 5000);
    chk(guard < 5000, "midreset_timeout", guard, 5000);
    #2;
    rst = 1'b0;
    shuffleFlag = 1'b0;
    exp_first = BIG;
    #1;
    chk(loadFlag === 1'b0 && card === 6'd0, "async_reset", int'({loadFlag, card}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int p;
    logic [5:0] l;

    fork
      forever begin
        @(negedge clk);
        check_cycle();
      end
    join_none

    // Pin the model helpers with hand-computed values.
    chk(lfsr_next(6'd1) == 6'd2, "model_step_1", int'(lfsr_next(6'd1)), 2);
    chk(lfsr_next(6'd16) == 6'd33, "model_step_16", int'(lfsr_next(6'd16)), 33);
    chk(lfsr_next(6'd48) == 6'd32, "model_step_48", int'(lfsr_next(6'd48)), 32);
    chk(mask_of(1) == 1, "model_mask_1", mask_of(1), 1);
    chk(mask_of(2) == 3, "model_mask_2", mask_of(2), 3);
    chk(mask_of(31) == 31, "model_mask_31", mask_of(31), 31);
    chk(mask_of(51) == 63, "model_mask_51", mask_of(51), 63);
    l = 6'd1;
    p = 0;
    do begin
      l = lfsr_next(l);
      p++;
    end while (l != 6'd1 && p < 100);
    chk(p == 63, "model_lfsr_period", p, 63);

    SEED = 6'b101011;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);

`ifndef SHUFFLE_FREE_RUN_LFSR_EN
    run_shuffle(6'b101011, 3, "perm_seed_2b");
    seq_a = got;
    run_shuffle(6'b101011, 4, "perm_seed_2b_again");
    seq_b = got;
    chk(diffs(seq_a, seq_b) == 0, "same_seed_same_seq", diffs(seq_a, seq_b), 0);
    run_shuffle(6'b000111, 3, "perm_seed_07");
    seq_c = got;
    chk(diffs(seq_a, seq_c) > 0, "seed_07_differs", diffs(seq_a, seq_c), 1);
    run_shuffle(6'd0, 2, "perm_seed_0");
    seq_0 = got;
    run_shuffle(6'd1, 6, "perm_seed_1");
    seq_1 = got;
    chk(diffs(seq_0, seq_1) == 0, "seed0_eq_seed1", diffs(seq_0, seq_1), 0);
    mid_stream_reset();
    run_shuffle(6'b101011, 3, "perm_after_reset");
    seq_d = got;
    chk(diffs(seq_a, seq_d) == 0, "after_reset_same_seq", diffs(seq_a, seq_d), 0);
`else
    do_reset();
    run_shuffle(6'b101011, 3, "perm_wait3");
    seq_a = got;
    do_reset();
    run_shuffle(6'b101011, 7, "perm_wait7");
    seq_b = got;
    chk(diffs(seq_a, seq_b) > 0, "wait_changes_seq", diffs(seq_a, seq_b), 1);
    mid_stream_reset();
    run_shuffle(6'b000111, 4, "perm_after_reset");
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
